// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives a word-indexed PC into instruction memory and
// buffers returned words in a 2-entry queue feeding decode via valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 100
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instruction_Code,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted,
  output logic        fault
);

  logic [31:0] r_pc;
  logic [31:0] r_q_pc   [2];
  logic [31:0] r_q_word [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_halted;
  logic        r_fault;

  logic w_pop;
  logic w_space;
  logic w_fetch_en;
  logic w_in_range;
  logic w_zero_word;
  logic w_push;

  assign w_pop       = inst_valid & inst_ready;
  assign w_space     = (r_count < 2'd2) | w_pop;
  assign w_fetch_en  = ~r_halted & ~r_fault & w_space & ~redirect;
  assign w_in_range  = r_pc < 32'(MEM_DEPTH);
  assign w_zero_word = (Instruction_Code == 32'h0);
  assign w_push      = w_fetch_en & w_in_range & ~w_zero_word;

  assign PC         = r_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst_out   = r_q_word[r_rd_ptr];
  assign inst_pc    = r_q_pc[r_rd_ptr];
  assign halted     = r_halted;
  assign fault      = r_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_q_pc[0]   <= 32'd0;
      r_q_pc[1]   <= 32'd0;
      r_q_word[0] <= 32'd0;
      r_q_word[1] <= 32'd0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_halted    <= 1'b0;
      r_fault     <= 1'b0;
    end else if (redirect) begin
      // Flush: any pop this cycle is simply absorbed by the reset of the queue.
      r_pc     <= redirect_pc;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_fetch_en) begin
        if (!w_in_range) begin
          r_fault <= 1'b1;
        end else if (w_zero_word) begin
          r_halted <= 1'b1;
        end else begin
          r_q_pc[r_wr_ptr]   <= r_pc;
          r_q_word[r_wr_ptr] <= Instruction_Code;
          r_wr_ptr           <= ~r_wr_ptr;
          r_pc               <= r_pc + 32'd1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit on the requester side of the instruction-memory read port. It drives the word-indexed `PC` into `inst_mem`, captures the combinationally returned `Instruction_Code`, and buffers fetched words in a 2-entry queue. The queue feeds decode through a valid/ready handshake. It also handles branch redirects, halts on an all-zero word, and flags fetches outside the memory range.

## Interface
- `RESET_PC`, 0: word address fetched first after reset.
- `MEM_DEPTH`, 100: number of valid instruction words. Legal PC range is 0..MEM_DEPTH-1.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset. It is sampled only on the rising edge of `clk`.
- `PC`  out  32  word index to instruction memory. This is a word index, not a byte address.
- `Instruction_Code`  in  32  word at `memory[PC]`, valid in the same cycle `PC` is driven.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new word index, sampled when `redirect`=1.
- `inst_valid`  out  1  queue head holds a valid instruction.
- `inst_out`  out  32  instruction word at the queue head.
- `inst_pc`  out  32  word index of `inst_out`.
- `inst_ready`  in  1  decode accepts the head this cycle.
- `halted`  out  1  an all-zero word was fetched and fetching has stopped.
- `fault`  out  1  `PC` reached or exceeded `MEM_DEPTH` and fetching has stopped.

## Operation
**State**
- PC register.
- 2-entry FIFO of {pc, word}, with read pointer, write pointer and a 2-bit count.
- `halted` and `fault` flags.

**Signal definitions**
- pop = `inst_valid` & `inst_ready`.
- space = (count<2) | pop.
- fetch_en = ~`halted` & ~`fault` & space & ~`redirect`.

**Priority per edge:** `reset` > `redirect` > normal fetch.

**Normal fetch (fetch_en=1)**
- If PC ≥ MEM_DEPTH: set `fault`. No enqueue. PC holds.
- Else if `Instruction_Code`==32'h0: set `halted`. No enqueue. PC holds.
- Else: enqueue {PC, `Instruction_Code`} and set PC ← PC+1. The increment is 32-bit and wraps, with no special case at 0xFFFFFFFF; the out-of-range check catches it first.
- fetch_en=0 with no redirect: PC holds, and the memory word is ignored.

**Pop**
- Pop advances the read pointer independently of fetch.
- Push and pop in the same cycle are allowed, including when count=2; count is then unchanged.

**Redirect**
- On `redirect`=1: count←0, both pointers←0, PC←`redirect_pc`, `halted`←0, `fault`←0.
- No enqueue in that cycle. A pop in that same cycle is still considered consumed by decode.

**Flag behavior**
- `halted` and `fault` are sticky; only `reset` or `redirect` clears them.
- The queue still drains while either flag is set.

**Output behavior**
- `inst_out` and `inst_pc` come directly from the head entry.
- When count=0 they hold their last value, and must be ignored while `inst_valid`=0.
- `inst_valid` = (count≠0).

## Timing
- **Reset values:** PC=`RESET_PC`, count=0, `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `halted`=0, `fault`=0.
- **Reset mid-operation:** queued entries are discarded on that edge.
- **Fetch latency:** `PC` is presented in cycle N, and the word is visible on `inst_out` with `inst_valid`=1 in cycle N+1 when the queue was empty.
- **Sustained throughput:** 1 instruction per cycle while `inst_ready`=1.
- **Backpressure:** with `inst_ready`=0, the queue fills after 2 fetches. PC then stalls on the third word's address, and that word is refetched when space opens.
- **Redirect timing:** `redirect` in cycle N → `PC`=`redirect_pc` in cycle N+1 → first new instruction valid in cycle N+2. There are no stale entries after N.
- **Halt/fault timing:** `halted` or `fault` asserts on the edge after the offending fetch cycle.

## Test plan
Memory model for the bench: mem[0]=0x09, mem[1]=0x0, mem[2..5]=0x11,0x22,0x33,0x44, mem[99]=0x55.

- **Reset, then fetch:** release `reset` with `inst_ready`=1 → cycle 1: `inst_out`=0x09, `inst_pc`=0. Next fetch at PC=1 sees 0x0 → `halted`=1, PC stays 1, no further `inst_valid`.
- **Redirect clears halt:** `redirect`=1 with `redirect_pc`=2 while halted → `halted`=0. Then 0x11, 0x22, 0x33, 0x44 are delivered on consecutive cycles, with `inst_pc` 2..5.
- **Backpressure:** redirect to 2 with `inst_ready`=0 for 4 cycles → count=2 with head 0x11, PC holds at 4. Then set `inst_ready`=1 → 0x11, 0x22, 0x33, 0x44 are delivered in order with no gap and no duplicate.
- **Redirect while full:** queue full, `redirect_pc`=99 → the next valid instruction is 0x55 with `inst_pc`=99. After that, PC=100 → `fault`=1 and no further valid.
- **Mid-stream reset:** assert `reset` for 1 cycle while count=2 and `fault`=0 → next cycle `inst_valid`=0, PC=0, both flags 0. The cycle after, 0x09 is valid.
- **Simultaneous push and pop at count=2:** count stays 2 and the order is preserved (checked with a scoreboard against the memory model).
